// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared state encoding and sizing constants for the SHA-256 sequencer
package sha256_pkg;
    localparam int ROUNDS    = 64;
    localparam int MSG_WORDS = 16;
    localparam int WORD_W    = 32;
    localparam int IDX_W     = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_MSG,
        ST_EXP,
        ST_FINAL,
        ST_DONE
    } state_t;
endpackage

// File: rtl/sha256_round_cnt.sv
// rtl/sha256_round_cnt.sv - round counter with clear, enable and two terminal-count flags
module sha256_round_cnt #(
    parameter int W      = 6,
    parameter int TERM_A = 15,
    parameter int TERM_B = 63
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         term_a,
    output logic         term_b
);
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + 1'b1;
    end

    assign term_a = (cnt == W'(TERM_A));
    assign term_b = (cnt == W'(TERM_B));
endmodule

// File: rtl/sha256_sched_ctrl.sv
// rtl/sha256_sched_ctrl.sv - control sequencer for one SHA-256 compression pass (no datapath)
module sha256_sched_ctrl
    import sha256_pkg::*;
#(
    parameter int ROUNDS    = 64,
    parameter int MSG_WORDS = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       blk_valid,
    input  logic       first_blk,
    input  logic       last_blk,
    output logic       blk_ready,
    input  logic       msg_valid,
    output logic       msg_ready,
    output logic [5:0] round_idx,
    output logic       w_shift,
    output logic       w_sel,
    output logic       iv_load,
    output logic       wv_load,
    output logic       round_en,
    output logic       h_update,
    output logic       digest_valid,
    input  logic       digest_ready,
    output logic       busy
);
    state_t state, state_nx;
    logic   first_q, last_q, armed;
    logic   cnt_en, cnt_clr, term_msg, term_rnd;

    sha256_round_cnt #(
        .W      (IDX_W),
        .TERM_A (MSG_WORDS - 1),
        .TERM_B (ROUNDS - 1)
    ) u_cnt (
        .CLK    (CLK),
        .RST    (RST),
        .en     (cnt_en),
        .clr    (cnt_clr),
        .cnt    (round_idx),
        .term_a (term_msg),
        .term_b (term_rnd)
    );

    // armed keeps blk_ready low until the first edge after reset release
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= ST_IDLE;
            armed   <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state <= state_nx;
            armed <= 1'b1;
            if (blk_valid && blk_ready) begin
                first_q <= first_blk;
                last_q  <= last_blk;
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (blk_valid && blk_ready) state_nx = ST_INIT;
            ST_INIT:  state_nx = ST_MSG;
            ST_MSG:   if (msg_valid && term_msg) state_nx = ST_EXP;
            ST_EXP:   if (term_rnd) state_nx = ST_FINAL;
            ST_FINAL: state_nx = last_q ? ST_DONE : ST_IDLE;
            ST_DONE:  if (digest_ready) state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        blk_ready    = (state == ST_IDLE) && armed;
        msg_ready    = (state == ST_MSG);
        w_sel        = (state == ST_EXP);
        w_shift      = ((state == ST_MSG) && msg_valid) || (state == ST_EXP);
        round_en     = w_shift;
        iv_load      = (state == ST_INIT) && first_q;
        wv_load      = (state == ST_INIT) && !first_q;
        h_update     = (state == ST_FINAL);
        digest_valid = (state == ST_DONE);
        busy         = (state != ST_IDLE);
        cnt_en       = w_shift && !((state == ST_EXP) && term_rnd);
        // round 63 clears rather than wraps so FINAL always sees round_idx 0
        cnt_clr      = (state == ST_EXP) && term_rnd;
    end
endmodule

// File: tb/tb_sha256_sched_ctrl.sv
// tb/tb_sha256_sched_ctrl.sv - self-checking bench for sha256_sched_ctrl
module tb_sha256_sched_ctrl;
    logic CLK = 1'b0, RST = 1'b1;
    logic blk_valid = 0, first_blk = 0, last_blk = 0, msg_valid = 0, digest_ready = 0;
    logic blk_ready, msg_ready, w_shift, w_sel, iv_load, wv_load, round_en;
    logic h_update, digest_valid, busy;
    logic [5:0] round_idx;

    sha256_sched_ctrl dut (
        .CLK(CLK), .RST(RST), .blk_valid(blk_valid), .first_blk(first_blk),
        .last_blk(last_blk), .blk_ready(blk_ready), .msg_valid(msg_valid),
        .msg_ready(msg_ready), .round_idx(round_idx), .w_shift(w_shift), .w_sel(w_sel),
        .iv_load(iv_load), .wv_load(wv_load), .round_en(round_en), .h_update(h_update),
        .digest_valid(digest_valid), .digest_ready(digest_ready), .busy(busy)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       blk_ready, msg_ready;
        logic [5:0] idx;
        logic       w_shift, w_sel, iv_load, wv_load, round_en, h_update, digest_valid, busy;
    } outs_t;

    typedef struct { bit bv; bit mv; bit dr; outs_t o; } cyc_t;

    typedef struct {
        bit first; bit last; bit rnd; int stall_at; int stall_len; int dr_delay; int exp_lat;
    } vec_t;

    int    checks = 0, errors = 0;
    cyc_t  plan[$];
    outs_t act;

    assign act = '{blk_ready, msg_ready, round_idx, w_shift, w_sel, iv_load, wv_load,
                   round_en, h_update, digest_valid, busy};

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, a, e);
        end
    endtask

    // Expected behaviour built as a per-cycle timeline from the block's word/stall pattern
    task automatic run_block(input vec_t v);
        cyc_t c;
        int words = 0, stalls = 0, lat, dv_at = -1, hu_cnt = 0;
        bit b;
        plan.delete();
        c.bv = $urandom; c.mv = $urandom; c.dr = $urandom;
        c.o = '0; c.o.busy = 1; c.o.iv_load = v.first; c.o.wv_load = !v.first;
        plan.push_back(c);
        while (words < 16) begin
            if (v.rnd) b = ($urandom_range(0, 3) != 0);
            else       b = !(words == v.stall_at && stalls < v.stall_len);
            if (!b) stalls++;
            c.bv = $urandom; c.mv = b; c.dr = $urandom;
            c.o = '0; c.o.busy = 1; c.o.msg_ready = 1; c.o.idx = 6'(words);
            c.o.w_shift = b; c.o.round_en = b;
            plan.push_back(c);
            if (b) words++;
        end
        for (int t = 16; t < 64; t++) begin
            c.bv = $urandom; c.mv = $urandom; c.dr = $urandom;
            c.o = '0; c.o.busy = 1; c.o.idx = 6'(t);
            c.o.w_shift = 1; c.o.w_sel = 1; c.o.round_en = 1;
            plan.push_back(c);
        end
        c.bv = $urandom; c.mv = $urandom; c.dr = $urandom;
        c.o = '0; c.o.busy = 1; c.o.h_update = 1;
        plan.push_back(c);
        if (v.last) begin
            for (int d = 0; d <= v.dr_delay; d++) begin
                c.bv = $urandom; c.mv = $urandom; c.dr = (d == v.dr_delay);
                c.o = '0; c.o.busy = 1; c.o.digest_valid = 1;
                plan.push_back(c);
            end
        end
        c.bv = 0; c.mv = $urandom; c.dr = $urandom;
        c.o = '0; c.o.blk_ready = 1;
        plan.push_back(c);
        lat = (v.exp_lat < 0) ? 66 + stalls : v.exp_lat;

        blk_valid = 1; first_blk = v.first; last_blk = v.last; msg_valid = $urandom;
        @(posedge CLK); #1;
        for (int i = 0; i < plan.size(); i++) begin
            blk_valid = plan[i].bv; msg_valid = plan[i].mv; digest_ready = plan[i].dr;
            first_blk = ~v.first; last_blk = ~v.last;
            @(negedge CLK);
            chk($sformatf("cycle%0d_outs", i), 32'(act), 32'(plan[i].o));
            chk("enable_onehot", 32'($countones({iv_load, wv_load, round_en, h_update}) <= 1), 1);
            chk("idx_range", 32'(round_idx <= 6'd63), 1);
            if (digest_valid && dv_at < 0) dv_at = i;
            if (h_update) hu_cnt++;
            @(posedge CLK); #1;
        end
        blk_valid = 0;
        chk("h_update_count", hu_cnt, 1);
        if (v.last) chk("digest_latency", dv_at, lat);
        else        chk("no_digest", dv_at, 32'hffffffff);
    endtask

    vec_t tbl[6];
    vec_t rv;

    initial begin
        int   n;
        outs_t idle_o;
        idle_o = '0; idle_o.blk_ready = 1;
        tbl[0] = '{1, 1, 0, -1, 0, 0, 66};
        tbl[1] = '{1, 1, 0, 7, 3, 0, 69};
        tbl[2] = '{1, 0, 0, -1, 0, 0, -1};
        tbl[3] = '{0, 1, 0, -1, 0, 0, 66};
        tbl[4] = '{1, 1, 0, -1, 0, 10, 66};
        tbl[5] = '{0, 0, 0, 15, 2, 0, -1};

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("reset_outs", 32'(act), 0);
        @(posedge CLK); #1; RST = 0;
        @(negedge CLK);
        chk("ready_before_edge", blk_ready, 0);
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("idle_after_release", 32'(act), 32'(idle_o));
        @(posedge CLK); #1;

        foreach (tbl[i]) run_block(tbl[i]);
        for (int k = 0; k < 6; k++) begin
            rv = '{$urandom, $urandom, 1, -1, 0, $urandom_range(0, 4), -1};
            run_block(rv);
        end

        // Abort mid-block at round 40
        blk_valid = 1; first_blk = 1; last_blk = 1; msg_valid = 1; digest_ready = 1;
        @(posedge CLK); #1; blk_valid = 0;
        n = 0;
        while (round_idx != 6'd40 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        chk("reach_idx40", 32'(round_idx), 40);
        RST = 1; #1;
        chk("abort_outs", 32'(act), 0);
        repeat (2) begin
            @(negedge CLK);
            chk("abort_no_hupdate", 32'(act), 0);
        end
        @(posedge CLK); #1; RST = 0;
        @(negedge CLK);
        chk("abort_ready_low", blk_ready, 0);
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("abort_ready_high", 32'(act), 32'(idle_o));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
